// File: rtl/rival_car_controller.sv
// -----------------------------------------------------------------------------
// rival_car_controller
// Produces the rival car position for the VGA racing game. The car spawns in a
// pseudo-random lane at the top of the road, scrolls down SPEED pixels per
// frame, respawns after leaving the screen, freezes on collision and restarts
// on the start pulse from the main game FSM.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   frame_tick   in   one-cycle pulse per VGA frame
//   start        in   one-cycle restart pulse
//   collision    in   level, high while the main car overlaps the rival
//   rival_x      out  rival sprite left x
//   rival_y      out  rival sprite top y
//   rival_active out  high in MOVE/FROZEN (sprite visible)
//   frozen       out  high in FROZEN
//   respawn      out  one-cycle pulse on every spawn
//   passed_cnt   out  rivals dodged since last start, saturating at 255
//   prng_q       out  current LFSR state
// -----------------------------------------------------------------------------
module rival_car_controller #(
  parameter logic [9:0]  ROAD_LEFT = 10'd160,
  parameter logic [9:0]  LANE_W    = 10'd80,
  parameter int unsigned LANE_BITS = 2,
  parameter logic [9:0]  SCREEN_H  = 10'd480,
  parameter logic [9:0]  SPEED     = 10'd2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       collision,
  output logic [9:0] rival_x,
  output logic [9:0] rival_y,
  output logic       rival_active,
  output logic       frozen,
  output logic       respawn,
  output logic [7:0] passed_cnt,
  output logic [7:0] prng_q
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [7:0]           lfsr_r;
  logic [7:0]           lfsr_nxt_s;
  logic [LANE_BITS-1:0] last_lane_r;
  logic [LANE_BITS-1:0] last_lane_nxt_s;
  logic [LANE_BITS-1:0] lane_raw_s;
  logic [LANE_BITS-1:0] lane_s;
  logic [9:0]           spawn_x_s;
  logic [10:0]          y_sum_s;
  logic [9:0]           x_nxt_s;
  logic [9:0]           y_nxt_s;
  logic [7:0]           passed_nxt_s;
  logic                 respawn_nxt_s;
  logic                 do_spawn_s;

  assign prng_q = lfsr_r;

  // Lane choice uses the pre-advance LFSR value; a repeat of the previous lane
  // is bumped to the next lane so consecutive rivals never share a lane.
  always_comb begin
    lane_raw_s = lfsr_r[LANE_BITS-1:0];
    if (lane_raw_s == last_lane_r) begin
      lane_s = lane_raw_s + LANE_BITS'(1'b1);
    end else begin
      lane_s = lane_raw_s;
    end
    spawn_x_s  = ROAD_LEFT + (LANE_W * 10'(lane_s));
    // 11-bit sum so the off-screen compare cannot be fooled by wrap-around
    y_sum_s    = {1'b0, rival_y} + {1'b0, SPEED};
    lfsr_nxt_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  end

  // Next-state and next-output logic: start > collision > frame_tick in MOVE.
  always_comb begin
    state_nxt_s     = state_r;
    x_nxt_s         = rival_x;
    y_nxt_s         = rival_y;
    last_lane_nxt_s = last_lane_r;
    passed_nxt_s    = passed_cnt;
    respawn_nxt_s   = 1'b0;
    do_spawn_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          do_spawn_s   = 1'b1;
          passed_nxt_s = 8'd0;
          state_nxt_s  = MOVE;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      MOVE: begin
        if (start) begin
          do_spawn_s   = 1'b1;
          passed_nxt_s = 8'd0;
        end else if (collision) begin
          state_nxt_s  = FROZEN;
        end else if (frame_tick) begin
          if (y_sum_s >= {1'b0, SCREEN_H}) begin
            do_spawn_s = 1'b1;
            if (passed_cnt == 8'hFF) begin
              passed_nxt_s = 8'hFF;
            end else begin
              passed_nxt_s = passed_cnt + 8'd1;
            end
          end else begin
            y_nxt_s = y_sum_s[9:0];
          end
        end else begin
          state_nxt_s = MOVE;
        end
      end
      FROZEN: begin
        if (start) begin
          do_spawn_s   = 1'b1;
          passed_nxt_s = 8'd0;
          state_nxt_s  = MOVE;
        end else begin
          state_nxt_s  = FROZEN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    if (do_spawn_s) begin
      x_nxt_s         = spawn_x_s;
      y_nxt_s         = 10'd0;
      last_lane_nxt_s = lane_s;
      respawn_nxt_s   = 1'b1;
    end else begin
      respawn_nxt_s   = 1'b0;
    end
  end

  // State, LFSR and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      lfsr_r       <= LFSR_SEED;
      last_lane_r  <= '0;
      rival_x      <= ROAD_LEFT;
      rival_y      <= 10'd0;
      rival_active <= 1'b0;
      frozen       <= 1'b0;
      respawn      <= 1'b0;
      passed_cnt   <= 8'd0;
    end else begin
      state_r      <= state_nxt_s;
      lfsr_r       <= lfsr_nxt_s;
      last_lane_r  <= last_lane_nxt_s;
      rival_x      <= x_nxt_s;
      rival_y      <= y_nxt_s;
      rival_active <= (state_nxt_s == MOVE) || (state_nxt_s == FROZEN);
      frozen       <= (state_nxt_s == FROZEN);
      respawn      <= respawn_nxt_s;
      passed_cnt   <= passed_nxt_s;
    end
  end

endmodule

// File: tb/tb_rival_car_controller.sv
// -----------------------------------------------------------------------------
// tb_rival_car_controller
// Self-checking bench: a reference model predicts the outputs after each clock
// and pushes them to a scoreboard queue; hand-computed vectors and sequences
// pin down the reset state, LFSR sequence, wrap, freeze, lane bump and reset.
// -----------------------------------------------------------------------------
module tb_rival_car_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       start;
  logic       collision;
  logic [9:0] rival_x;
  logic [9:0] rival_y;
  logic       rival_active;
  logic       frozen;
  logic       respawn;
  logic [7:0] passed_cnt;
  logic [7:0] prng_q;

  always #5 clk = ~clk;

  rival_car_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .start        (start),
    .collision    (collision),
    .rival_x      (rival_x),
    .rival_y      (rival_y),
    .rival_active (rival_active),
    .frozen       (frozen),
    .respawn      (respawn),
    .passed_cnt   (passed_cnt),
    .prng_q       (prng_q)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       frz;
    logic       resp;
    logic [7:0] passed;
    logic [7:0] prng;
  } obs_t;

  typedef struct {
    logic st;
    logic co;
    logic ft;
    obs_t exp;
  } vec_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  int         m_state;   // 0 idle, 1 move, 2 frozen
  logic [7:0] m_lfsr;
  logic [9:0] m_x;
  logic [9:0] m_y;
  logic [1:0] m_last;
  logic       m_resp;
  logic [7:0] m_passed;

  function automatic obs_t mk(input logic [9:0] x, input logic [9:0] y, input logic a,
                              input logic f, input logic r, input logic [7:0] p,
                              input logic [7:0] q);
    obs_t o;
    o.x = x; o.y = y; o.active = a; o.frz = f; o.resp = r; o.passed = p; o.prng = q;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    return mk(rival_x, rival_y, rival_active, frozen, respawn, passed_cnt, prng_q);
  endfunction

  function automatic obs_t model_obs();
    return mk(m_x, m_y, (m_state != 0), (m_state == 2), m_resp, m_passed, m_lfsr);
  endfunction

  task automatic model_reset();
    m_state = 0; m_lfsr = 8'hA5; m_x = 10'd160; m_y = 10'd0;
    m_last = 2'd0; m_resp = 1'b0; m_passed = 8'd0;
  endtask

  task automatic model_clock(input logic st, input logic co, input logic ft);
    logic [7:0] l;
    logic [1:0] lane;
    bit         spawn;
    int         ny;
    l = m_lfsr;
    spawn = 0;
    m_resp = 1'b0;
    if (m_state == 0) begin
      if (st) begin spawn = 1; m_passed = 8'd0; m_state = 1; end
    end else if (m_state == 1) begin
      if (st) begin
        spawn = 1; m_passed = 8'd0;
      end else if (co) begin
        m_state = 2;
      end else if (ft) begin
        ny = int'(m_y) + 2;
        if (ny >= 480) begin
          spawn = 1;
          if (m_passed != 8'd255) m_passed = m_passed + 8'd1;
        end else begin
          m_y = 10'(ny);
        end
      end
    end else begin
      if (st) begin spawn = 1; m_passed = 8'd0; m_state = 1; end
    end
    if (spawn) begin
      lane = l[1:0];
      if (lane == m_last) lane = lane + 2'd1;
      m_x = 10'(160 + int'(lane) * 80);
      m_y = 10'd0;
      m_last = lane;
      m_resp = 1'b1;
    end
    m_lfsr = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, got, req);
    end
  endtask

  // Drive one cycle of inputs, predict, clock, then compare against the scoreboard.
  task automatic step(input logic st, input logic co, input logic ft);
    obs_t e;
    start = st; collision = co; frame_tick = ft;
    model_clock(st, co, ft);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check("scoreboard", 64'(dut_obs()), 64'(e));
    end
    start = 1'b0; collision = 1'b0; frame_tick = 1'b0;
  endtask

  vec_t vecs[7];
  int   cnt;
  bit   found;

  initial begin
    rst_n = 1'b0; start = 1'b0; collision = 1'b0; frame_tick = 1'b0;
    model_reset();

    // directed table from the pre-advance seed A5 (lane 1 -> x=240)
    vecs[0] = '{1'b1, 1'b0, 1'b0, mk(10'd240, 10'd0,  1'b1, 1'b0, 1'b1, 8'd0, 8'h4A)};
    vecs[1] = '{1'b0, 1'b0, 1'b1, mk(10'd240, 10'd2,  1'b1, 1'b0, 1'b0, 8'd0, 8'h95)};
    vecs[2] = '{1'b0, 1'b0, 1'b1, mk(10'd240, 10'd4,  1'b1, 1'b0, 1'b0, 8'd0, 8'h2A)};
    vecs[3] = '{1'b0, 1'b0, 1'b1, mk(10'd240, 10'd6,  1'b1, 1'b0, 1'b0, 8'd0, 8'h54)};
    vecs[4] = '{1'b0, 1'b0, 1'b1, mk(10'd240, 10'd8,  1'b1, 1'b0, 1'b0, 8'd0, 8'hA9)};
    vecs[5] = '{1'b0, 1'b0, 1'b1, mk(10'd240, 10'd10, 1'b1, 1'b0, 1'b0, 8'd0, 8'h53)};
    vecs[6] = '{1'b0, 1'b0, 1'b0, mk(10'd240, 10'd10, 1'b1, 1'b0, 1'b0, 8'd0, 8'hA7)};

    #12;
    rst_n = 1'b1;
    check("reset_state", 64'(dut_obs()), 64'(mk(10'd160, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'hA5)));

    // LFSR runs in IDLE; collision and frame_tick are ignored there
    step(1'b0, 1'b0, 1'b0);
    check("prng_4a", 64'(prng_q), 64'(8'h4A));
    step(1'b0, 1'b0, 1'b0);
    check("prng_95", 64'(prng_q), 64'(8'h95));
    step(1'b0, 1'b1, 1'b1);
    check("idle_ignore", 64'(dut_obs()), 64'(mk(10'd160, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h2A)));

    // re-reset so the start lands on the A5 edge
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rereset", 64'(dut_obs()), 64'(mk(10'd160, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'hA5)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      step(vecs[i].st, vecs[i].co, vecs[i].ft);
      check($sformatf("vec%0d", i), 64'(dut_obs()), 64'(vecs[i].exp));
    end

    // ticks 6..239 bring y to 478, tick 240 wraps
    for (int i = 0; i < 234; i++) step(1'b0, 1'b0, 1'b1);
    check("y_478", 64'(rival_y), 64'(10'd478));
    step(1'b0, 1'b0, 1'b1);
    check("wrap_y", 64'(rival_y), 64'(10'd0));
    check("wrap_resp", 64'(respawn), 64'(1'b1));
    check("wrap_passed", 64'(passed_cnt), 64'(8'd1));
    check("wrap_new_lane", 64'(rival_x != 10'd240), 64'(1'b1));

    // freeze at y=100; ticks and collision ignored while frozen
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1);
    check("y_100", 64'(rival_y), 64'(10'd100));
    step(1'b0, 1'b1, 1'b0);
    check("frozen_set", 64'(frozen), 64'(1'b1));
    for (int i = 0; i < 10; i++) step(1'b0, i[0], 1'b1);
    check("frozen_hold", 64'({frozen, rival_active, rival_y, passed_cnt}),
          64'({1'b1, 1'b1, 10'd100, 8'd1}));
    step(1'b1, 1'b0, 1'b0);
    check("restart", 64'({frozen, respawn, rival_y, passed_cnt}),
          64'({1'b0, 1'b1, 10'd0, 8'd0}));

    // lane bump: first land in lane 3, then spawn again with lfsr[1:0]==3
    found = 0;
    for (cnt = 0; cnt < 300 && !found; cnt++) begin
      if (m_lfsr[1:0] == 2'd3 && m_last != 2'd3) found = 1;
      else step(1'b0, 1'b0, 1'b0);
    end
    check("wait_lane3", 64'(found), 64'(1'b1));
    step(1'b1, 1'b0, 1'b0);
    check("lane3_x", 64'(rival_x), 64'(10'd400));
    found = 0;
    for (cnt = 0; cnt < 300 && !found; cnt++) begin
      if (m_lfsr[1:0] == 2'd3) found = 1;
      else step(1'b0, 1'b0, 1'b0);
    end
    check("wait_repeat", 64'(found), 64'(1'b1));
    step(1'b1, 1'b0, 1'b0);
    check("bump_x", 64'(rival_x), 64'(10'd160));

    // start together with collision in MOVE: restart wins
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("start_coll", 64'({rival_active, frozen, respawn, rival_y}),
          64'({1'b1, 1'b0, 1'b1, 10'd0}));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

    // asynchronous reset mid-move
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", 64'(dut_obs()), 64'(mk(10'd160, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'hA5)));
    @(posedge clk);
    #1;
    check("reset_held", 64'(prng_q), 64'(8'hA5));
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("post_reset_prng", 64'(prng_q), 64'(8'h4A));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
